// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read per instruction over req/ack,
// and hands fetched words to decode over valid/ready. Handles flush redirects and halt.
module inst_fetch_unit #(
  parameter int                         INST_ADDR_WIDTH = 16,
  parameter int                         INST_WIDTH      = 16,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_ADDR_WIDTH-1:0] pc_next,
  input  logic                       halt,
  input  logic                       flush,
  output logic [INST_ADDR_WIDTH-1:0] pc_cur,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic                       inst_valid,
  output logic [INST_WIDTH-1:0]      inst,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  input  logic                       inst_ready,
  output logic                       halted,
  output logic [1:0]                 state_dbg
);

  // Handshakes: imem_req stays high with imem_addr stable until a cycle with imem_ack=1,
  // and that cycle completes the read; inst_valid stays high with inst/inst_pc stable
  // until a cycle with inst_ready=1 (or flush), and that cycle completes the transfer.

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  state_e state;
  state_e state_nxt;
  logic   flush_pend;

  logic fetch_take;
  logic fetch_drop;
  logic fetch_flush;
  logic dlv_flush;
  logic dlv_hand;
  logic rst_start;

  // A flush seen earlier in this request (flush_pend) or in the ack cycle itself poisons the data.
  always_comb begin
    rst_start   = (state == ST_RESET) && !halt;
    fetch_take  = (state == ST_FETCH) && imem_ack && !flush_pend && !flush;
    fetch_drop  = (state == ST_FETCH) && imem_ack && (flush_pend || flush);
    fetch_flush = (state == ST_FETCH) && flush;
    dlv_flush   = (state == ST_DELIVER) && flush;
    dlv_hand    = (state == ST_DELIVER) && !flush && inst_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:   state_nxt = halt ? ST_HALTED : ST_FETCH;
      ST_FETCH:   if (fetch_take) state_nxt = ST_DELIVER;
      ST_DELIVER: if (flush || inst_ready) state_nxt = halt ? ST_HALTED : ST_FETCH;
      ST_HALTED:  state_nxt = ST_HALTED;
      default:    state_nxt = ST_RESET;
    endcase
  end

  always_comb begin
    imem_req  = (state == ST_FETCH);
    halted    = (state == ST_HALTED);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_cur     <= RESET_PC;
      imem_addr  <= RESET_PC;
      flush_pend <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      if (fetch_take || fetch_flush || dlv_flush) begin
        pc_cur <= pc_next;
      end

      // A flush in the ack cycle means pc_cur is being rewritten now, so use pc_next directly.
      if (rst_start) begin
        imem_addr <= pc_cur;
      end else if (fetch_drop) begin
        imem_addr <= flush ? pc_next : pc_cur;
      end else if (dlv_flush) begin
        imem_addr <= pc_next;
      end else if (dlv_hand) begin
        imem_addr <= pc_cur;
      end

      if (fetch_drop) begin
        flush_pend <= 1'b0;
      end else if (fetch_flush) begin
        flush_pend <= 1'b1;
      end

      if (fetch_take) begin
        inst       <= imem_rdata;
        inst_pc    <= imem_addr;
        inst_valid <= 1'b1;
      end else if (dlv_flush || dlv_hand) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: pc_adder and instruction memory are modelled here,
// request addresses and deliveries are checked against expected queues.
module tb_inst_fetch_unit;

  localparam int             AW       = 16;
  localparam int             IW       = 16;
  localparam logic [AW-1:0]  RESET_PC = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_next;
  logic          halt = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] pc_cur;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          halted;
  logic [1:0]    state_dbg;

  logic          redir_en = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  int            ack_delay = 0;
  int            wait_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    req_exp_q[$];

  typedef struct {
    int            ack_delay;
    int            stall;
    logic [AW-1:0] exp_pc;
    logic [IW-1:0] exp_inst;
  } vec_t;
  vec_t vecs[7];

  inst_fetch_unit #(.INST_ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .halt(halt), .flush(flush),
    .pc_cur(pc_cur), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .halted(halted), .state_dbg(state_dbg)
  );

  // pc_adder stand-in: redirect target on a taken redirect, hold on halt, else +1.
  assign pc_next = redir_en ? redir_pc : (halt ? pc_cur : pc_cur + 16'd1);

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 16'h0101) ^ 16'hC35A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic h);
    rst_n = 1'b0; flush = 1'b0; redir_en = 1'b0; inst_ready = 1'b0; halt = h; ack_delay = 0;
    tick();
    tick();
    check("rst_pc_cur", pc_cur, RESET_PC);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_imem_req", imem_req, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_dbg, 0);
    if (!h) req_exp_q.push_back(RESET_PC);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    int cyc;
    cyc = 0;
    while (!inst_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("valid_timeout", inst_valid, 1);
  endtask

  // ---------------- driver: one table vector = one sequential fetch/deliver ----------------
  task automatic run_vec(input vec_t v);
    int req_cycles;
    int cyc;
    ack_delay  = v.ack_delay;
    inst_ready = (v.stall == 0);
    exp_q.push_back({v.exp_pc, v.exp_inst});
    req_cycles = 0;
    cyc = 0;
    while (!inst_valid && cyc < 40) begin
      if (imem_req) req_cycles++;
      tick();
      cyc++;
    end
    check("deliver_timeout", inst_valid, 1);
    check("req_cycles", req_cycles, v.ack_delay + 1);
    check("pc_advanced", pc_cur, v.exp_pc + 16'd1);
    for (int s = 0; s < v.stall; s++) begin
      check("stall_valid", inst_valid, 1);
      check("stall_inst", {inst_pc, inst}, {v.exp_pc, v.exp_inst});
      check("stall_req", imem_req, 0);
      tick();
    end
    inst_ready = 1'b1;
    req_exp_q.push_back(v.exp_pc + 16'd1);
    tick();
    check("resume_req", imem_req, 1);
  endtask

  // ---------------- instruction memory responder ----------------
  initial begin
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (imem_req) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); wait_cnt = 0;
        end else begin
          imem_ack = 1'b0; imem_rdata = '0; wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0; imem_rdata = '0; wait_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic          prev_req;
    logic          prev_ack;
    logic [AW-1:0] prev_addr;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_req = 1'b0; prev_ack = 1'b0;
      end else begin
        if (imem_req && (!prev_req || prev_ack)) begin
          if (req_exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL req_unexpected: got request at 0x%0h expected none", imem_addr);
          end else begin
            check("req_addr", imem_addr, req_exp_q.pop_front());
          end
        end else if (imem_req && prev_req && !prev_ack) begin
          check("req_addr_stable", imem_addr, prev_addr);
        end
        if (inst_valid && inst_ready && !flush) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL deliver_unexpected: got pc 0x%0h inst 0x%0h expected none", inst_pc, inst);
          end else begin
            check("deliver", {inst_pc, inst}, exp_q.pop_front());
          end
        end
        if (halted) check("halted_quiet", {imem_req, inst_valid}, 0);
        prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{0, 0, 16'd0, mem_word(16'd0)};
    vecs[1] = '{0, 0, 16'd1, mem_word(16'd1)};
    vecs[2] = '{0, 0, 16'd2, mem_word(16'd2)};
    vecs[3] = '{2, 0, 16'd3, mem_word(16'd3)};
    vecs[4] = '{0, 3, 16'd4, mem_word(16'd4)};
    vecs[5] = '{1, 1, 16'd5, mem_word(16'd5)};
    vecs[6] = '{3, 2, 16'd6, mem_word(16'd6)};

    do_reset(1'b0);
    check("cycle0_req", imem_req, 0);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // flush in DELIVER of addr 7: dropped, redirect to 10
    ack_delay = 0; inst_ready = 1'b0;
    wait_valid();
    check("dlv7_pc", inst_pc, 16'd7);
    flush = 1'b1; redir_en = 1'b1; redir_pc = 16'd10; inst_ready = 1'b1; ack_delay = 2;
    req_exp_q.push_back(16'd10);
    tick();
    flush = 1'b0; redir_en = 1'b0; inst_ready = 1'b0;
    check("dflush_pc", pc_cur, 16'd10);
    check("dflush_addr", imem_addr, 16'd10);
    check("dflush_valid", inst_valid, 0);
    check("dflush_req", imem_req, 1);
    tick();
    // flush one cycle before the delayed ack at addr 10
    flush = 1'b1; redir_en = 1'b1; redir_pc = 16'd500;
    tick();
    flush = 1'b0; redir_en = 1'b0;
    check("fflush_addr_held", imem_addr, 16'd10);
    check("fflush_pc", pc_cur, 16'd500);
    check("fflush_req", imem_req, 1);
    req_exp_q.push_back(16'd500);
    exp_q.push_back({16'd500, mem_word(16'd500)});
    tick();
    ack_delay = 0;
    check("fflush_new_addr", imem_addr, 16'd500);
    check("fflush_no_valid", inst_valid, 0);
    inst_ready = 1'b1;
    wait_valid();
    req_exp_q.push_back(16'd501);
    tick();
    check("after500_pc", pc_cur, 16'd501);

    // flush and ack in the same FETCH cycle
    flush = 1'b1; redir_en = 1'b1; redir_pc = 16'd700;
    req_exp_q.push_back(16'd700);
    tick();
    flush = 1'b0; redir_en = 1'b0; inst_ready = 1'b0;
    check("fack_addr", imem_addr, 16'd700);
    check("fack_pc", pc_cur, 16'd700);
    check("fack_valid", inst_valid, 0);
    wait_valid();
    check("dlv700_pc", inst_pc, 16'd700);

    // flush + halt in DELIVER: dropped, halted
    flush = 1'b1; halt = 1'b1; redir_en = 1'b1; redir_pc = 16'd40; inst_ready = 1'b1;
    tick();
    flush = 1'b0; redir_en = 1'b0;
    check("fh_halted", halted, 1);
    check("fh_pc", pc_cur, 16'd40);
    check("fh_req", imem_req, 0);

    // async reset out of HALTED
    rst_n = 1'b0;
    #1;
    check("async_halted", halted, 0);
    check("async_pc", pc_cur, RESET_PC);

    // halt during DELIVER of addr 3
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) run_vec(vecs[i]);
    ack_delay = 0; inst_ready = 1'b0;
    exp_q.push_back({16'd3, mem_word(16'd3)});
    wait_valid();
    halt = 1'b1; inst_ready = 1'b1;
    tick();
    check("halt_halted", halted, 1);
    check("halt_req", imem_req, 0);
    check("halt_valid", inst_valid, 0);
    check("halt_pc", pc_cur, 16'd4);
    for (int i = 0; i < 4; i++) begin
      flush = 1'b1; redir_en = 1'b1; redir_pc = 16'd900; halt = i[0];
      tick();
      check("halt_frozen_pc", pc_cur, 16'd4);
      check("halt_stays", halted, 1);
    end
    flush = 1'b0; redir_en = 1'b0; halt = 1'b0;

    // halt in RESET state
    do_reset(1'b1);
    tick();
    check("rhalt_halted", halted, 1);
    check("rhalt_req", imem_req, 0);
    halt = 1'b0;
    tick();
    check("rhalt_stays", halted, 1);

    // reset while request outstanding at addr 7
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    ack_delay = 5; inst_ready = 1'b0;
    tick();
    check("mid_req", imem_req, 1);
    check("mid_addr", imem_addr, 16'd7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", inst_valid, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_pc", pc_cur, RESET_PC);
    check("mid_rst_addr", imem_addr, RESET_PC);
    do_reset(1'b0);
    for (int i = 0; i < 2; i++) run_vec(vecs[i]);
    tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("req_q_empty", req_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
